core_cache_bridge: RTL
======================

// Module: core_cache_bridge
// PURPOSE
//  Registered request bridge between the rvsteel core IO port and the split L1I/L1D cache ports.
//  Decodes instruction/data regions by address and enforces a one-outstanding-request handshake.
//  Performs true byte-lane read-modify-write for partial stores, since L1D accepts full words only.
//  Adds a per-request timeout with a sticky error flag.
//  Sits between u_cpu and the cache top, replacing the combinational glue at that point.
// PARAMETERS
//  DATA_WIDTH   32          word width; must be a multiple of 8; STRB_W = DATA_WIDTH/8
//  ADDR_WIDTH   32          address width
//  INST_END     32'h11fd8   last instruction-region address; addr <= INST_END -> L1I, else L1D
//  TIMEOUT      1024        cycles to wait for cache ready before abort; 0 disables timeout
//  ERR_DATA     32'hDEADBEEF  read_data returned on an aborted or illegal read
// PORTS
//  clk             in   1           single clock
//  rst             in   1           asynchronous reset, active-high
//  rw_address      in   ADDR_WIDTH  core address
//  read_request    in   1           core read strobe
//  write_request   in   1           core write strobe
//  write_data      in   DATA_WIDTH  core store data, lane-aligned
//  write_strobe    in   STRB_W      byte enables
//  read_data       out  DATA_WIDTH  registered read data
//  read_response   out  1           1-cycle pulse: read done
//  write_response  out  1           1-cycle pulse: write done
//  i_rd            out  1           L1I read request (level)
//  i_addr          out  ADDR_WIDTH  L1I address
//  i_rdata         in   DATA_WIDTH  L1I data
//  i_ready         in   1           L1I ready pulse
//  d_rd / d_wr     out  1           L1D read / write request (level)
//  d_addr          out  ADDR_WIDTH  L1D address
//  d_wdata         out  DATA_WIDTH  L1D full-word write data
//  d_rdata         in   DATA_WIDTH  L1D data
//  d_ready         in   1           L1D ready pulse
//  err             out  1           sticky error; cleared only by rst
//  busy            out  1           FSM not in IDLE
// BEHAVIOUR
//  Reset (async, any state): FSM=IDLE; all outputs 0, including read_data, err, and every cache request.
//  Core requests are sampled only in IDLE. Address, data, and strobe are latched on acceptance.
//  Core inputs are ignored while busy=1.
//  Read and write in the same cycle: the write is served and the read is dropped.
//  FSM states: IDLE, I_RD, D_RD, RMW_RD, D_WR, RESP_R, RESP_W.
//  IDLE transitions:
//   - read, addr <= INST_END: go to I_RD.
//   - read, addr > INST_END: go to D_RD.
//   - write, strobe all-ones: go to D_WR.
//   - write, strobe nonzero and partial: go to RMW_RD.
//   - write, strobe zero: go to RESP_W, no cache access.
//   - write, addr <= INST_END: illegal; set err, go to RESP_W, no cache access.
//  I_RD / D_RD:
//   - Request held high until the ready of that port is sampled.
//   - On ready, capture rdata and go to RESP_R.
//  RMW_RD:
//   - Hold d_rd until d_ready is sampled.
//   - merged[8k+7:8k] = strobe[k] ? write_data lane k : d_rdata lane k.
//   - Go to D_WR with d_wdata = merged.
//  D_WR: hold d_wr until d_ready is sampled, then go to RESP_W.
//  RESP_R: read_response=1 for one cycle; read_data holds its value until the next read completes.
//  RESP_W: write_response=1 for one cycle.
//  From RESP_R or RESP_W, go to IDLE.
//  Latency, counted from request in IDLE, with ready arriving N cycles after the cache request rises:
//   - read: N+2 cycles.
//   - full write: N+2 cycles.
//   - partial write: N1+N2+3 cycles.
//  d_rd and d_wr are never high together, and i_rd and d_* are never high together.
//  Timeout, per wait state:
//   - The counter resets on state entry.
//   - Reaching TIMEOUT drops the request, sets err, and goes to RESP_R (read_data=ERR_DATA) or RESP_W.
//   - ready arriving in the same cycle as the timeout wins: no error.
//  Stray ready pulses outside a wait state are ignored.
// TESTING
//  T1: read 0x100d8, i_ready after 3 cycles with 0x00000513 -> i_rd high 3 cycles; read_response 1 pulse; read_data=0x00000513.
//  T2: write 0x20000, strobe 0010, data 0x0000AB00, d_rdata=0x11223344 -> d_rd then d_wr; d_wdata=0x1122AB44; one write_response.
//  T3: write 0x20004, strobe 1111, data 0xCAFEF00D -> d_rd stays 0; d_wdata=0xCAFEF00D; one write_response.
//  T4: TIMEOUT=8, read 0x20000 with no d_ready -> abort after 8 cycles; read_data=0xDEADBEEF; err=1 until rst.
//  T5: read and write together at 0x20000 -> only the write is performed; no read_response.
//  T6: assert rst mid-RMW_RD -> d_rd=0 immediately; busy=0; then a new read completes normally.

Source files
------------

// File: rtl/core_cache_bridge.sv
`default_nettype none
// ============================================================================
// Module   : core_cache_bridge
// Brief    : Registered bridge from the rvsteel core IO port to split L1I/L1D
//            ports, with byte-lane read-modify-write, timeout and sticky error.
// Revision : 1.0 - initial release
// ============================================================================
module core_cache_bridge #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] INST_END   = ADDR_WIDTH'(32'h11fd8),
    parameter int                    TIMEOUT    = 1024,
    parameter logic [DATA_WIDTH-1:0] ERR_DATA   = DATA_WIDTH'(32'hDEADBEEF)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   rw_address,
    input  logic                    read_request,
    input  logic                    write_request,
    input  logic [DATA_WIDTH-1:0]   write_data,
    input  logic [DATA_WIDTH/8-1:0] write_strobe,
    output logic [DATA_WIDTH-1:0]   read_data,
    output logic                    read_response,
    output logic                    write_response,
    output logic                    i_rd,
    output logic [ADDR_WIDTH-1:0]   i_addr,
    input  logic [DATA_WIDTH-1:0]   i_rdata,
    input  logic                    i_ready,
    output logic                    d_rd,
    output logic                    d_wr,
    output logic [ADDR_WIDTH-1:0]   d_addr,
    output logic [DATA_WIDTH-1:0]   d_wdata,
    input  logic [DATA_WIDTH-1:0]   d_rdata,
    input  logic                    d_ready,
    output logic                    err,
    output logic                    busy
);

    localparam int c_strb_w = DATA_WIDTH / 8;
    localparam int c_cnt_w  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_cnt_w-1:0] c_to_last = (TIMEOUT > 0) ? c_cnt_w'(TIMEOUT - 1) : '0;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_I_RD   = 3'd1,
        S_D_RD   = 3'd2,
        S_RMW_RD = 3'd3,
        S_D_WR   = 3'd4,
        S_RESP_R = 3'd5,
        S_RESP_W = 3'd6
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [c_strb_w-1:0]     strb_q, strb_d;
    logic [DATA_WIDTH-1:0]   d_wdata_q, d_wdata_d;
    logic [DATA_WIDTH-1:0]   read_data_q, read_data_d;
    logic [c_cnt_w-1:0]      cnt_q, cnt_d;
    logic                    err_q, err_d;
    logic                    i_rd_q, i_rd_d;
    logic                    d_rd_q, d_rd_d;
    logic                    d_wr_q, d_wr_d;
    logic                    rresp_q, rresp_d;
    logic                    wresp_q, wresp_d;
    logic                    busy_q, busy_d;

    logic [DATA_WIDTH-1:0]   w_merged;
    logic                    w_wait_ready;
    logic                    w_timed_out;

    // Lanes not enabled by the store keep the word just read from L1D.
    for (genvar k = 0; k < c_strb_w; k++) begin : g_lane
        assign w_merged[8*k +: 8] = strb_q[k] ? wdata_q[8*k +: 8] : d_rdata[8*k +: 8];
    end

    assign w_wait_ready = (state_q == S_I_RD) ? i_ready : d_ready;
    assign w_timed_out  = (TIMEOUT != 0) && (cnt_q == c_to_last);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        strb_d      = strb_q;
        d_wdata_d   = d_wdata_q;
        read_data_d = read_data_q;
        cnt_d       = cnt_q;
        err_d       = err_q;

        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (write_request) begin
                    addr_d  = rw_address;
                    wdata_d = write_data;
                    strb_d  = write_strobe;
                    if (rw_address <= INST_END) begin
                        err_d   = 1'b1;
                        state_d = S_RESP_W;
                    end else if (write_strobe == '0) begin
                        state_d = S_RESP_W;
                    end else if (&write_strobe) begin
                        d_wdata_d = write_data;
                        state_d   = S_D_WR;
                    end else begin
                        state_d = S_RMW_RD;
                    end
                end else if (read_request) begin
                    addr_d  = rw_address;
                    state_d = (rw_address <= INST_END) ? S_I_RD : S_D_RD;
                end
            end
            S_I_RD, S_D_RD, S_RMW_RD, S_D_WR: begin
                // A ready in the final timeout cycle still completes normally.
                if (w_wait_ready) begin
                    cnt_d = '0;
                    case (state_q)
                        S_I_RD: begin
                            read_data_d = i_rdata;
                            state_d     = S_RESP_R;
                        end
                        S_D_RD: begin
                            read_data_d = d_rdata;
                            state_d     = S_RESP_R;
                        end
                        S_RMW_RD: begin
                            d_wdata_d = w_merged;
                            state_d   = S_D_WR;
                        end
                        default: state_d = S_RESP_W;
                    endcase
                end else if (w_timed_out) begin
                    cnt_d = '0;
                    err_d = 1'b1;
                    if (state_q == S_I_RD || state_q == S_D_RD) begin
                        read_data_d = ERR_DATA;
                        state_d     = S_RESP_R;
                    end else begin
                        state_d = S_RESP_W;
                    end
                end else begin
                    cnt_d = cnt_q + c_cnt_w'(1);
                end
            end
            S_RESP_R, S_RESP_W: state_d = S_IDLE;
            default:            state_d = S_IDLE;
        endcase

        i_rd_d  = (state_d == S_I_RD);
        d_rd_d  = (state_d == S_D_RD) || (state_d == S_RMW_RD);
        d_wr_d  = (state_d == S_D_WR);
        rresp_d = (state_d == S_RESP_R);
        wresp_d = (state_d == S_RESP_W);
        busy_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            strb_q      <= '0;
            d_wdata_q   <= '0;
            read_data_q <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            i_rd_q      <= 1'b0;
            d_rd_q      <= 1'b0;
            d_wr_q      <= 1'b0;
            rresp_q     <= 1'b0;
            wresp_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            strb_q      <= strb_d;
            d_wdata_q   <= d_wdata_d;
            read_data_q <= read_data_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            i_rd_q      <= i_rd_d;
            d_rd_q      <= d_rd_d;
            d_wr_q      <= d_wr_d;
            rresp_q     <= rresp_d;
            wresp_q     <= wresp_d;
            busy_q      <= busy_d;
        end
    end

    assign read_data      = read_data_q;
    assign read_response  = rresp_q;
    assign write_response = wresp_q;
    assign i_rd           = i_rd_q;
    assign i_addr         = addr_q;
    assign d_rd           = d_rd_q;
    assign d_wr           = d_wr_q;
    assign d_addr         = addr_q;
    assign d_wdata        = d_wdata_q;
    assign err            = err_q;
    assign busy           = busy_q;

endmodule
`default_nettype wire
